// File: rtl/adder_arbiter_20b_pkg.sv
// ============================================================================
// Module      : adder_arbiter_20b_pkg
// Description : Shared widths, requester-id encoding and pipeline tag type
//               for the two-requester arbitrated adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arbiter_20b_pkg;

  localparam int WIDTH_DEF = 20;
  localparam int CNT_W_DEF = 8;
  localparam int BLK_W     = 4;

  typedef enum logic {
    REQ_ID0 = 1'b0,
    REQ_ID1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } tag_t;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_ID0) ? REQ_ID1 : REQ_ID0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/naive_carry_select_adder_20b.sv
// ============================================================================
// Module      : naive_carry_select_adder_20b
// Description : Registered carry-select adder built from BLK_W-bit blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module naive_carry_select_adder_20b
  import adder_arbiter_20b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   sum_o
);

  localparam int NUM_BLK = (WIDTH + BLK_W - 1) / BLK_W;

  logic [NUM_BLK:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   sum_q;

  assign w_carry[0] = cin_i;

  // Each block precomputes both carry-in outcomes; the ripple only drives muxes.
  generate
    for (genvar i = 0; i < NUM_BLK; i++) begin : g_blk
      localparam int LO = i * BLK_W;
      localparam int BW = ((WIDTH - LO) < BLK_W) ? (WIDTH - LO) : BLK_W;

      logic [BW:0] w_s0;
      logic [BW:0] w_s1;

      assign w_s0 = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]};
      assign w_s1 = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]} + (BW+1)'(1);

      assign w_sum[LO +: BW] = w_carry[i] ? w_s1[BW-1:0] : w_s0[BW-1:0];
      assign w_carry[i+1]    = w_carry[i] ? w_s1[BW]     : w_s0[BW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_q <= '0;
    end else begin
      sum_q <= {w_carry[NUM_BLK], w_sum};
    end
  end

  assign sum_o = sum_q;

endmodule

`default_nettype wire

// File: rtl/adder_arbiter_20b.sv
// ============================================================================
// Module      : adder_arbiter_20b
// Description : Round-robin arbiter sharing one pipelined adder between two
//               requesters, with tagged responses and completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter_20b
  import adder_arbiter_20b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH:0]   rsp_sum,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  req_id_e          ptr_q, ptr_d;
  logic             acc_d;
  req_id_e          acc_id_d;
  logic [WIDTH-1:0] acc_a_d, acc_b_d;

  logic [WIDTH-1:0] op_a_q, op_b_q;
  tag_t             tag1_q, tag2_q;
  logic [WIDTH:0]   add_sum;
  logic             rsp0_q, rsp1_q;
  logic [WIDTH:0]   rsp_sum_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Grant decision: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ptr_d      = ptr_q;
    acc_d      = 1'b0;
    acc_id_d   = REQ_ID0;
    if (rstn && en) begin
      if (req0_valid && (!req1_valid || ptr_q == REQ_ID0)) begin
        acc_d    = 1'b1;
        acc_id_d = REQ_ID0;
      end else if (req1_valid) begin
        acc_d    = 1'b1;
        acc_id_d = REQ_ID1;
      end
    end
    if (acc_d) begin
      req0_ready = (acc_id_d == REQ_ID0);
      req1_ready = (acc_id_d == REQ_ID1);
      ptr_d      = other_id(acc_id_d);
    end
  end

  assign acc_a_d = (acc_id_d == REQ_ID1) ? req1_a : req0_a;
  assign acc_b_d = (acc_id_d == REQ_ID1) ? req1_b : req0_b;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q  <= REQ_ID0;
      op_a_q <= '0;
      op_b_q <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      if (acc_d) begin
        op_a_q <= acc_a_d;
        op_b_q <= acc_b_d;
      end
      tag1_q <= tag_t'{vld: acc_d, id: acc_id_d};
      tag2_q <= tag1_q;
    end
  end

  naive_carry_select_adder_20b #(
    .WIDTH (WIDTH)
  ) u_adder (
    .clk   (clk),
    .rstn  (rstn),
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .cin_i (1'b0),
    .sum_o (add_sum)
  );

  // Response stage: sum is only reloaded when a tagged op arrives.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      rsp_sum_q <= '0;
    end else begin
      rsp0_q <= tag2_q.vld && (tag2_q.id == REQ_ID0);
      rsp1_q <= tag2_q.vld && (tag2_q.id == REQ_ID1);
      if (tag2_q.vld) begin
        rsp_sum_q <= add_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (rsp0_q) begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (rsp1_q) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_sum    = rsp_sum_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign busy       = tag1_q.vld | tag2_q.vld;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter_20b.sv
// ============================================================================
// Module      : tb_adder_arbiter_20b
// Description : Scoreboard bench: driver models grants and pushes expected
//               responses; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter_20b;
  import adder_arbiter_20b_pkg::*;

  localparam int W  = WIDTH_DEF;
  localparam int CW = CNT_W_DEF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [W:0]    rsp_sum;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  adder_arbiter_20b dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_sum    (rsp_sum),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .busy       (busy)
  );

  typedef struct {
    int          id;
    logic [W:0]  sum;
    int unsigned due;
  } exp_t;

  exp_t          sb_q[$];
  int unsigned   cyc = 0;
  int            ptr_m = 0;
  logic [CW-1:0] cnt_m [2];
  int            n_vec = 0;
  int            n_bad = 0;
  bit            mon_on = 1'b0;

  // Arbitration rule: lone requester wins, a tie goes to the pointer.
  function automatic int grant_m();
    if (!rstn || !en) return -1;
    if (req0_valid && req1_valid) return ptr_m;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // One rising edge of the reference model, then move off the edge to drive.
  task automatic tick();
    int         g;
    logic [W:0] s;
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      sb_q.delete();
      ptr_m    = 0;
      cnt_m[0] = '0;
      cnt_m[1] = '0;
    end else begin
      g = grant_m();
      if (g >= 0) begin
        s = (g == 1) ? ({1'b0, req1_a} + {1'b0, req1_b})
                     : ({1'b0, req0_a} + {1'b0, req0_b});
        sb_q.push_back('{id: g, sum: s, due: cyc + 2});
        ptr_m = 1 - g;
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    int          g;
    bit          busy_m;
    logic [1:0]  exp_rsp;
    exp_t        e;
    if (mon_on) begin
      g = grant_m();
      chk("req0_ready", 32'(req0_ready), 32'(g == 0));
      chk("req1_ready", 32'(req1_ready), 32'(g == 1));
      busy_m = 1'b0;
      foreach (sb_q[i]) if (sb_q[i].due > cyc) busy_m = 1'b1;
      chk("busy", 32'(busy), 32'(busy_m));
      chk("cnt0", 32'(cnt0), 32'(cnt_m[0]));
      chk("cnt1", 32'(cnt1), 32'(cnt_m[1]));
      exp_rsp = 2'b00;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        exp_rsp[e.id] = 1'b1;
        chk("rsp_strobes", 32'({rsp1_valid, rsp0_valid}), 32'(exp_rsp));
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        cnt_m[e.id] = cnt_m[e.id] + 1'b1;
      end else begin
        chk("rsp_strobes", 32'({rsp1_valid, rsp0_valid}), 32'(exp_rsp));
      end
    end
  end

  initial begin
    cnt_m[0] = '0;
    cnt_m[1] = '0;

    rstn = 1'b0;
    tick();
    mon_on = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    en   = 1'b1;
    tick();

    // Single requester, small operands.
    req0_valid = 1'b1; req0_a = W'(1); req0_b = W'(2);
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();

    // Full carry out of the top bit.
    req1_valid = 1'b1; req1_a = '1; req1_b = '1;
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();

    // Contention straight after reset: grants must alternate from requester 0.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (4) begin
      req0_a = rand_op(); req0_b = rand_op();
      req1_a = rand_op(); req1_b = rand_op();
      tick();
    end

    // Grant enable low with both still requesting.
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (2) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Reset with two operations in flight.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (4) tick();

    // 256 back-to-back requester-0 ops: counter wraps to zero.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    req0_valid = 1'b1;
    repeat (256) begin
      req0_a = rand_op(); req0_b = rand_op();
      tick();
    end
    req0_valid = 1'b0;
    repeat (4) tick();

    // Randomised mix of enable, valids and operands.
    repeat (100) begin
      en         = ($urandom_range(0, 3) != 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = rand_op(); req0_b = rand_op();
      req1_a = rand_op(); req1_b = rand_op();
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b1;
    repeat (5) tick();

    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending responses expected 0", sb_q.size());
    end

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_arbiter_20b.md
ADDER_ARBITER_20B -- requirements
Module: adder_arbiter_20b

Interface
REQ-001 Parameter: WIDTH, 20, operand width; sum width is WIDTH+1.
REQ-002 Parameter: CNT_W, 8, width of per-requester completion counters.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rstn  input  1  reset, synchronous, active-low.
REQ-005 Port: en  input  1  grant enable; low blocks new grants, in-flight ops complete.
REQ-006 Port: req0_valid / req1_valid  input  1  requester operand pair valid.
REQ-007 Port: req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 Port: req0_ready / req1_ready  output  1  grant; accept occurs when valid & ready at a rising edge.
REQ-009 Port: rsp0_valid / rsp1_valid  output  1  one-cycle result strobe for the requester.
REQ-010 Port: rsp_sum  output  WIDTH+1  result, valid while either rsp strobe is high.
REQ-011 Port: cnt0 / cnt1  output  CNT_W  completed operations per requester.
REQ-012 Port: busy  output  1  high while any accepted op has not yet responded.

Function
REQ-013 reqN_ready SHALL be combinational from en, req valids and priority pointer; at most one ready high per cycle.
REQ-014 Only one requester valid with en high -> that requester SHALL be granted regardless of pointer.
REQ-015 Both valid with en high -> the requester indicated by the priority pointer SHALL be granted.
REQ-016 After a grant to requester k, the pointer SHALL point to the other requester; no grant -> pointer unchanged.
REQ-017 en low -> both readys low; pointer unchanged.
REQ-018 Accepted operands SHALL be captured into an operand register (stage 1), fed to the shared adder with cin=0; adder registers the sum (stage 2).
REQ-019 Latency: accept at edge E -> rspN_valid and rsp_sum valid in the cycle after edge E+2; fixed, no backpressure.
REQ-020 A tag pipeline (valid bit + requester id) SHALL travel alongside stages 1-2; only the tagged requester's rsp strobe asserts.
REQ-021 Throughput: one accept per cycle sustained; back-to-back accepts yield back-to-back responses in accept order.
REQ-022 rsp_sum SHALL equal a+b modulo 2^(WIDTH+1) (full carry, no truncation).
REQ-023 cntN SHALL increment by 1 in the cycle after rspN_valid is high; wraps from 2^CNT_W-1 to 0.
REQ-024 busy SHALL be high when any tag-pipeline valid bit is set.
REQ-025 rsp_sum SHALL hold its last value when no strobe is high (value don't-care to requesters).

Reset
REQ-026 rstn low at a rising edge: pointer=0, tag valids=0, cnt0=cnt1=0, rsp strobes=0, busy=0, operand register=0.
REQ-027 Reset mid-operation SHALL drop all in-flight ops; no response strobe SHALL appear for them after rstn rises.
REQ-028 While rstn is low, req0_ready and req1_ready SHALL be low.
REQ-029 Shared adder SHALL receive the same rstn; sum register reset value 0.

Structure
REQ-030 WIDTH, CNT_W defaults and requester-id encoding (0/1) SHALL reside in a shared package/include used by block and bench.
REQ-031 Sub-module: naive_carry_select_adder_20b, instantiated once as the shared datapath; no other adder logic in this block.

Verification
REQ-032 Single requester: req0 a=0x00001, b=0x00002 -> req0_ready same cycle, rsp0_valid 2 edges later, rsp_sum=0x000003, cnt0=1.
REQ-033 Carry: req1 a=0xFFFFF, b=0xFFFFF -> rsp1_valid, rsp_sum=0x1FFFFE.
REQ-034 Contention: both valid continuously for 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp0/rsp1 with correct sums.
REQ-035 en=0 for 3 cycles with both valid -> no readys, busy falls after pipeline drains, pointer unchanged on re-enable.
REQ-036 Reset with 2 ops in flight -> no rsp strobes afterward, cnt0=cnt1=0, busy=0.
REQ-037 Counter wrap: 256 req0 ops -> cnt0 returns to 0; 100-vector file set of a/b/sum checked with zero mismatches.
